display_scan8: RTL

Eight-digit multiplexed 7-segment display driver. It consumes the eight 6-bit display codes produced by the game and status blocks and drives one shared active-low cathode bus and eight active-low anodes. It time-multiplexes the digits, adds per-digit blinking, and latches all eight codes once per frame so a frame never mixes old and new values. It sits between the game FSM's `d1`..`d8` outputs and the board's display pins.

---
 rtl/disp_pkg.sv | 42 ++++
 rtl/seg7_decode.sv | 57 +++++
 rtl/display_scan8.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared display-code definitions: code field layout, glyph names and
// active-low 7-segment patterns ({dp,g,f,e,d,c,b,a}).
package disp_pkg;

  localparam int CODE_W          = 6;
  localparam int SEG_W           = 8;
  localparam int CODE_SPECIAL_BIT = 5;
  localparam int CODE_GLYPH_MSB  = 4;
  localparam int CODE_GLYPH_LSB  = 1;
  localparam int CODE_DP_BIT     = 0;
  localparam int SEG_DP_BIT      = 7;

  localparam logic [3:0] G_P = 4'hA;
  localparam logic [3:0] G_B = 4'hB;
  localparam logic [3:0] G_C = 4'hC;
  localparam logic [3:0] G_S = 4'hD;
  localparam logic [3:0] G_E = 4'hE;
  localparam logic [3:0] G_U = 4'hF;

  localparam logic [CODE_W-1:0] CODE_DASH  = 6'h3F;
  localparam logic [CODE_W-1:0] CODE_BLANK = 6'h20;

  localparam logic [SEG_W-1:0] SEG_0     = 8'hC0;
  localparam logic [SEG_W-1:0] SEG_1     = 8'hF9;
  localparam logic [SEG_W-1:0] SEG_2     = 8'hA4;
  localparam logic [SEG_W-1:0] SEG_3     = 8'hB0;
  localparam logic [SEG_W-1:0] SEG_4     = 8'h99;
  localparam logic [SEG_W-1:0] SEG_5     = 8'h92;
  localparam logic [SEG_W-1:0] SEG_6     = 8'h82;
  localparam logic [SEG_W-1:0] SEG_7     = 8'hF8;
  localparam logic [SEG_W-1:0] SEG_8     = 8'h80;
  localparam logic [SEG_W-1:0] SEG_9     = 8'h90;
  localparam logic [SEG_W-1:0] SEG_P     = 8'h8C;
  localparam logic [SEG_W-1:0] SEG_B     = 8'h83;
  localparam logic [SEG_W-1:0] SEG_C     = 8'hA7;
  localparam logic [SEG_W-1:0] SEG_S     = 8'h92;
  localparam logic [SEG_W-1:0] SEG_E     = 8'h86;
  localparam logic [SEG_W-1:0] SEG_U     = 8'hC1;
  localparam logic [SEG_W-1:0] SEG_DASH  = 8'hBF;
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seg7_decode.sv
// Combinational decode of one 6-bit display code into an active-low
// cathode pattern.
module seg7_decode
  import disp_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  output logic [SEG_W-1:0]  o_seg
);

  logic                w_special;
  logic                w_dp;
  logic [3:0]          w_glyph;
  logic [SEG_W-1:0]    w_glyph_seg;

  assign w_special = i_code[CODE_SPECIAL_BIT];
  assign w_glyph   = i_code[CODE_GLYPH_MSB:CODE_GLYPH_LSB];
  assign w_dp      = i_code[CODE_DP_BIT];

  always_comb begin
    w_glyph_seg = SEG_BLANK;
    case (w_glyph)
      4'h0:    w_glyph_seg = SEG_0;
      4'h1:    w_glyph_seg = SEG_1;
      4'h2:    w_glyph_seg = SEG_2;
      4'h3:    w_glyph_seg = SEG_3;
      4'h4:    w_glyph_seg = SEG_4;
      4'h5:    w_glyph_seg = SEG_5;
      4'h6:    w_glyph_seg = SEG_6;
      4'h7:    w_glyph_seg = SEG_7;
      4'h8:    w_glyph_seg = SEG_8;
      4'h9:    w_glyph_seg = SEG_9;
      G_P:     w_glyph_seg = SEG_P;
      G_B:     w_glyph_seg = SEG_B;
      G_C:     w_glyph_seg = SEG_C;
      G_S:     w_glyph_seg = SEG_S;
      G_E:     w_glyph_seg = SEG_E;
      G_U:     w_glyph_seg = SEG_U;
      default: w_glyph_seg = SEG_BLANK;
    endcase
  end

  // Special codes ignore the decimal point; only the dash glyph lights anything.
  always_comb begin
    o_seg = SEG_BLANK;
    if (w_special) begin
      if (w_glyph == CODE_DASH[CODE_GLYPH_MSB:CODE_GLYPH_LSB]) begin
        o_seg = SEG_DASH;
      end else begin
        o_seg = SEG_BLANK;
      end
    end else begin
      o_seg             = w_glyph_seg;
      o_seg[SEG_DP_BIT] = w_glyph_seg[SEG_DP_BIT] & ~w_dp;
    end
  end

endmodule

// File: rtl/display_scan8.sv
// Eight-digit multiplexed 7-segment scanner with per-frame shadow latch,
// anti-ghosting guard cycles and per-digit blinking.
module display_scan8
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CODE_W-1:0] d1,
  input  logic [CODE_W-1:0] d2,
  input  logic [CODE_W-1:0] d3,
  input  logic [CODE_W-1:0] d4,
  input  logic [CODE_W-1:0] d5,
  input  logic [CODE_W-1:0] d6,
  input  logic [CODE_W-1:0] d7,
  input  logic [CODE_W-1:0] d8,
  input  logic [7:0]        blink,
  output logic [7:0]        an,
  output logic [SEG_W-1:0]  dec_cat,
  output logic              frame_start
);

  localparam int PRE_W  = $clog2(REFRESH_DIV);
  localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PRE_W-1:0]  PRE_ZERO   = {PRE_W{1'b0}};
  localparam logic [PRE_W-1:0]  PRE_ONE    = PRE_W'(32'd1);
  localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0]  PRE_GUARD  = PRE_W'(GUARD);
  localparam logic [FCNT_W-1:0] FCNT_ZERO  = {FCNT_W{1'b0}};
  localparam logic [FCNT_W-1:0] FCNT_ONE   = FCNT_W'(32'd1);
  localparam logic [FCNT_W-1:0] FCNT_LAST  = FCNT_W'(BLINK_FRAMES - 1);

  logic [PRE_W-1:0]  r_pre;
  logic [2:0]        r_slot;
  logic [FCNT_W-1:0] r_fcnt;
  logic              r_phase;

  logic [CODE_W-1:0] r_shadow [8];
  logic [7:0]        r_shadow_blink;

  logic [7:0]        r_an;
  logic [SEG_W-1:0]  r_dec_cat;
  logic              r_frame_start;

  logic [CODE_W-1:0] w_d [8];
  logic              w_capture;
  logic [7:0]        w_slot_mask;
  logic [CODE_W-1:0] w_code;
  logic [SEG_W-1:0]  w_seg;
  logic              w_blank;
  logic [7:0]        w_an_nxt;
  logic [SEG_W-1:0]  w_cat_nxt;

  assign w_d[0] = d1;
  assign w_d[1] = d2;
  assign w_d[2] = d3;
  assign w_d[3] = d4;
  assign w_d[4] = d5;
  assign w_d[5] = d6;
  assign w_d[6] = d7;
  assign w_d[7] = d8;

  assign w_capture   = (r_pre == PRE_ZERO) && (r_slot == 3'd0);
  // Slot k drives an[7-k]; the same mask selects its blink bit.
  assign w_slot_mask = 8'h80 >> r_slot;
  assign w_code      = r_shadow[r_slot];
  assign w_blank     = (|(r_shadow_blink & w_slot_mask)) & r_phase;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pre   <= PRE_ZERO;
      r_slot  <= 3'd0;
      r_fcnt  <= FCNT_ZERO;
      r_phase <= 1'b0;
    end else if (r_pre == PRE_LAST) begin
      r_pre  <= PRE_ZERO;
      r_slot <= r_slot + 3'd1;
      if (r_slot == 3'd7) begin
        if (r_fcnt == FCNT_LAST) begin
          r_fcnt  <= FCNT_ZERO;
          r_phase <= ~r_phase;
        end else begin
          r_fcnt <= r_fcnt + FCNT_ONE;
        end
      end
    end else begin
      r_pre <= r_pre + PRE_ONE;
    end
  end

  // Whole-frame snapshot so one frame never mixes old and new codes.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin
        r_shadow[i] <= CODE_BLANK;
      end
      r_shadow_blink <= 8'h00;
    end else if (w_capture) begin
      for (int i = 0; i < 8; i++) begin
        r_shadow[i] <= w_d[i];
      end
      r_shadow_blink <= blink;
    end
  end

  seg7_decode u_decode (
    .i_code (w_code),
    .o_seg  (w_seg)
  );

  always_comb begin
    w_an_nxt  = 8'hFF;
    w_cat_nxt = SEG_BLANK;
    if (r_pre < PRE_GUARD) begin
      w_an_nxt  = 8'hFF;
      w_cat_nxt = SEG_BLANK;
    end else begin
      w_an_nxt = ~w_slot_mask;
      if (w_blank) begin
        w_cat_nxt = SEG_BLANK;
      end else begin
        w_cat_nxt = w_seg;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_an          <= 8'hFF;
      r_dec_cat     <= SEG_BLANK;
      r_frame_start <= 1'b0;
    end else begin
      r_an          <= w_an_nxt;
      r_dec_cat     <= w_cat_nxt;
      r_frame_start <= w_capture;
    end
  end

  assign an          = r_an;
  assign dec_cat     = r_dec_cat;
  assign frame_start = r_frame_start;

endmodule
